// File: rtl/e203_exu_brslv_q_pkg.sv
// Shared types and constants for the commit-stage branch resolve unit.
// Holds the flush FSM encoding, the sequential PC increments and the counter-enable helper.
package e203_exu_brslv_q_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } brslv_state_e;

   localparam int unsigned PC_INC_32 = 4;
   localparam int unsigned PC_INC_16 = 2;

   // Which side effect a redirect carries; pulsed out on the IFU handshake.
   typedef struct packed {
      logic mret;
      logic dret;
      logic fencei;
   } flush_kind_t;

   function automatic logic cnt_enabled(input int unsigned en);
      return (en != 0);
   endfunction

endpackage

// File: rtl/e203_exu_brslv_tgt.sv
// Redirect target computation for a committing branch/jump/FENCE.I/MRET/DRET.
// Purely combinational so it can feed either the registered or the pass-through flush path.
module e203_exu_brslv_tgt
   import e203_exu_brslv_q_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] imm,
   input  logic            rv32,
   input  logic            bjp,
   input  logic            prdt,
   input  logic            fencei,
   input  logic            mret,
   input  logic            dret,
   input  logic [PC_W-1:0] epc,
   input  logic [PC_W-1:0] dpc,
   output logic [PC_W-1:0] tgt_pc
);

   logic [PC_W-1:0] seq_inc;
   logic [PC_W-1:0] pc_seq;
   logic [PC_W-1:0] pc_off;

   assign seq_inc = rv32 ? PC_W'(PC_INC_32) : PC_W'(PC_INC_16);
   assign pc_seq  = pc + seq_inc;
   assign pc_off  = pc + imm;

   // A predicted-taken branch that resolved not-taken falls through to the next instruction.
   always_comb begin
      tgt_pc = pc_off;
      if (dret) begin
         tgt_pc = dpc;
      end else if (mret) begin
         tgt_pc = epc;
      end else if (fencei || (bjp && prdt)) begin
         tgt_pc = pc_seq;
      end
   end

endmodule

// File: rtl/e203_exu_brslv_q.sv
// Commit-stage branch resolve unit: raises IFU redirects, BHT updates and prediction statistics.
// REG_FLUSH selects a registered, ack-held flush request or the legacy combinational path.
module e203_exu_brslv_q
   import e203_exu_brslv_q_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter int XLEN      = 32,
   parameter int REG_FLUSH = 1,
   parameter int CNT_W     = 32,
   parameter int CNT_EN    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmt_i_valid,
   output logic             cmt_i_ready,
   input  logic             cmt_i_rv32,
   input  logic             cmt_i_bjp,
   input  logic             cmt_i_bxx,
   input  logic             cmt_i_bjp_prdt,
   input  logic             cmt_i_bjp_rslv,
   input  logic             cmt_i_fencei,
   input  logic             cmt_i_mret,
   input  logic             cmt_i_dret,
   input  logic [PC_W-1:0]  cmt_i_pc,
   input  logic [XLEN-1:0]  cmt_i_imm,
   input  logic [PC_W-1:0]  csr_epc_r,
   input  logic [PC_W-1:0]  csr_dpc_r,
   input  logic             nonalu_excpirq_flush_req_raw,
   output logic             brchmis_flush_req,
   input  logic             brchmis_flush_ack,
   output logic [PC_W-1:0]  brchmis_flush_pc,
   output logic             cmt_mret_ena,
   output logic             cmt_dret_ena,
   output logic             cmt_fencei_ena,
   output logic             bht_upd_valid,
   output logic [PC_W-1:0]  bht_upd_pc,
   output logic             bht_upd_taken,
   output logic             bht_upd_mis,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_bxx,
   output logic [CNT_W-1:0] stat_bxxmis
);

   logic            is_br;
   logic            mispred;
   logic            need_flush;
   logic            cmt_accept;
   logic [PC_W-1:0] tgt_pc;
   flush_kind_t     cur_kind;

   logic            flush_req_w;
   logic            ready_w;
   logic [PC_W-1:0] flush_pc_w;
   flush_kind_t     ena_w;

   assign is_br      = cmt_i_bjp | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
   assign mispred    = cmt_i_bjp_prdt ^ cmt_i_bjp_rslv;
   assign need_flush = (cmt_i_bjp & mispred) | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
   assign cmt_accept = cmt_i_valid & ready_w;

   assign cur_kind.mret   = cmt_i_mret;
   assign cur_kind.dret   = cmt_i_dret;
   assign cur_kind.fencei = cmt_i_fencei;

   e203_exu_brslv_tgt #(
      .PC_W (PC_W)
   ) u_tgt (
      .pc     (cmt_i_pc),
      .imm    (cmt_i_imm[PC_W-1:0]),
      .rv32   (cmt_i_rv32),
      .bjp    (cmt_i_bjp),
      .prdt   (cmt_i_bjp_prdt),
      .fencei (cmt_i_fencei),
      .mret   (cmt_i_mret),
      .dret   (cmt_i_dret),
      .epc    (csr_epc_r),
      .dpc    (csr_dpc_r),
      .tgt_pc (tgt_pc)
   );

   generate
      if (REG_FLUSH != 0) begin : g_reg_flush
         brslv_state_e    state_reg;
         brslv_state_e    state_next;
         logic [PC_W-1:0] tgt_reg;
         flush_kind_t     kind_reg;
         logic            flush_start;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_reg <= IDLE;
               tgt_reg   <= '0;
               kind_reg  <= '0;
            end else begin
               state_reg <= state_next;
               if (flush_start) begin
                  tgt_reg  <= tgt_pc;
                  kind_reg <= cur_kind;
               end
            end
         end

         // While a redirect is pending the commit stage is frozen and the exception flush is ignored.
         always_comb begin
            state_next  = state_reg;
            ready_w     = 1'b0;
            flush_req_w = 1'b0;
            flush_start = 1'b0;
            ena_w       = '0;
            case (state_reg)
               IDLE: begin
                  ready_w = ~is_br | ~nonalu_excpirq_flush_req_raw;
                  if (cmt_i_valid && need_flush && !nonalu_excpirq_flush_req_raw) begin
                     flush_start = 1'b1;
                     state_next  = PEND;
                  end
               end
               PEND: begin
                  flush_req_w = 1'b1;
                  if (brchmis_flush_ack) begin
                     ena_w      = kind_reg;
                     state_next = IDLE;
                  end
               end
               default: state_next = IDLE;
            endcase
         end

         assign flush_pc_w = tgt_reg;
      end else begin : g_comb_flush
         always_comb begin
            flush_req_w = cmt_i_valid & need_flush & ~nonalu_excpirq_flush_req_raw;
            ready_w     = ~is_br
                        | ((need_flush ? brchmis_flush_ack : 1'b1) & ~nonalu_excpirq_flush_req_raw);
            ena_w.mret   = flush_req_w & brchmis_flush_ack & cmt_i_mret;
            ena_w.dret   = flush_req_w & brchmis_flush_ack & cmt_i_dret;
            ena_w.fencei = flush_req_w & brchmis_flush_ack & cmt_i_fencei;
         end

         assign flush_pc_w = tgt_pc;
      end
   endgenerate

   assign cmt_i_ready       = ready_w;
   assign brchmis_flush_req = flush_req_w;
   assign brchmis_flush_pc  = flush_pc_w;
   assign cmt_mret_ena      = ena_w.mret;
   assign cmt_dret_ena      = ena_w.dret;
   assign cmt_fencei_ena    = ena_w.fencei;

   // BHT training strobe, one cycle after each accepted conditional branch.
   logic            bht_valid_reg;
   logic [PC_W-1:0] bht_pc_reg;
   logic            bht_taken_reg;
   logic            bht_mis_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bht_valid_reg <= 1'b0;
         bht_pc_reg    <= '0;
         bht_taken_reg <= 1'b0;
         bht_mis_reg   <= 1'b0;
      end else begin
         bht_valid_reg <= cmt_accept & cmt_i_bxx;
         if (cmt_accept && cmt_i_bxx) begin
            bht_pc_reg    <= cmt_i_pc;
            bht_taken_reg <= cmt_i_bjp_rslv;
            bht_mis_reg   <= mispred;
         end
      end
   end

   assign bht_upd_valid = bht_valid_reg;
   assign bht_upd_pc    = bht_pc_reg;
   assign bht_upd_taken = bht_taken_reg;
   assign bht_upd_mis   = bht_mis_reg;

   generate
      if (cnt_enabled(CNT_EN)) begin : g_cnt
         logic [1:0]       cnt_inc;
         logic [CNT_W-1:0] cnt_w [2];

         // Slot 0 counts correct predictions, slot 1 mispredictions.
         assign cnt_inc[0] = cmt_accept & cmt_i_bxx & ~mispred;
         assign cnt_inc[1] = cmt_accept & cmt_i_bxx & mispred;

         for (genvar gi = 0; gi < 2; gi++) begin : g_ctr
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  cnt_reg <= '0;
               end else if (stat_clr) begin
                  cnt_reg <= '0;
               end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            assign cnt_w[gi] = cnt_reg;
         end

         assign stat_bxx    = cnt_w[0];
         assign stat_bxxmis = cnt_w[1];
      end else begin : g_no_cnt
         logic cnt_unused;
         assign cnt_unused  = stat_clr;
         assign stat_bxx    = '0;
         assign stat_bxxmis = '0;
      end
   endgenerate

endmodule

// File: tb/tb_e203_exu_brslv_q.sv
// Directed bench for e203_exu_brslv_q: registered-flush instance with 2-bit counters
// plus a pass-through instance, with queue scoreboards for BHT updates and redirects.
module tb_e203_exu_brslv_q;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic        mis;
      int          cyc;
   } bht_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        mret;
      logic        dret;
      logic        fencei;
      int          cyc;
   } fl_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v1, v0;
   logic        rv32, bjp, bxx, prdt, rslv, fencei, mret, dret;
   logic [31:0] pc, imm, epc, dpc;
   logic        nonalu, ack, stat_clr;

   logic        r1, req1, mret1, dret1, fen1, bv1, bt1, bm1;
   logic [31:0] fpc1, bpc1;
   logic [1:0]  sb1, sm1;
   logic        r0, req0, mret0, dret0, fen0, bv0, bt0, bm0;
   logic [31:0] fpc0, bpc0, sb0, sm0;

   int   n_vec = 0;
   int   n_mis = 0;
   int   cyc = 0;
   logic mon_en = 1'b0;
   logic fl_seen = 1'b0;
   bht_t bq[$];
   fl_t  fq[$];
   bht_t be;
   int   exp_b, exp_m;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   e203_exu_brslv_q #(.PC_W(32), .XLEN(32), .REG_FLUSH(1), .CNT_W(2), .CNT_EN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .cmt_i_valid(v1), .cmt_i_ready(r1), .cmt_i_rv32(rv32),
      .cmt_i_bjp(bjp), .cmt_i_bxx(bxx), .cmt_i_bjp_prdt(prdt), .cmt_i_bjp_rslv(rslv),
      .cmt_i_fencei(fencei), .cmt_i_mret(mret), .cmt_i_dret(dret), .cmt_i_pc(pc),
      .cmt_i_imm(imm), .csr_epc_r(epc), .csr_dpc_r(dpc),
      .nonalu_excpirq_flush_req_raw(nonalu), .brchmis_flush_req(req1),
      .brchmis_flush_ack(ack), .brchmis_flush_pc(fpc1), .cmt_mret_ena(mret1),
      .cmt_dret_ena(dret1), .cmt_fencei_ena(fen1), .bht_upd_valid(bv1), .bht_upd_pc(bpc1),
      .bht_upd_taken(bt1), .bht_upd_mis(bm1), .stat_clr(stat_clr), .stat_bxx(sb1),
      .stat_bxxmis(sm1));

   e203_exu_brslv_q #(.PC_W(32), .XLEN(32), .REG_FLUSH(0), .CNT_W(32), .CNT_EN(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .cmt_i_valid(v0), .cmt_i_ready(r0), .cmt_i_rv32(rv32),
      .cmt_i_bjp(bjp), .cmt_i_bxx(bxx), .cmt_i_bjp_prdt(prdt), .cmt_i_bjp_rslv(rslv),
      .cmt_i_fencei(fencei), .cmt_i_mret(mret), .cmt_i_dret(dret), .cmt_i_pc(pc),
      .cmt_i_imm(imm), .csr_epc_r(epc), .csr_dpc_r(dpc),
      .nonalu_excpirq_flush_req_raw(nonalu), .brchmis_flush_req(req0),
      .brchmis_flush_ack(ack), .brchmis_flush_pc(fpc0), .cmt_mret_ena(mret0),
      .cmt_dret_ena(dret0), .cmt_fencei_ena(fen0), .bht_upd_valid(bv0), .bht_upd_pc(bpc0),
      .bht_upd_taken(bt0), .bht_upd_mis(bm0), .stat_clr(stat_clr), .stat_bxx(sb0),
      .stat_bxxmis(sm0));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic clr_in();
      v1 = 0; v0 = 0; rv32 = 1; bjp = 0; bxx = 0; prdt = 0; rslv = 0;
      fencei = 0; mret = 0; dret = 0; pc = 0; imm = 0; nonalu = 0; ack = 0; stat_clr = 0;
   endtask

   task automatic br(input logic c, input logic p, input logic r, input logic w32,
                     input logic [31:0] a, input logic [31:0] i);
      clr_in();
      v1 = 1; bjp = 1; bxx = c; prdt = p; rslv = r; rv32 = w32; pc = a; imm = i;
      $display("txn branch bxx=%0b prdt=%0b rslv=%0b rv32=%0b pc=%08h imm=%08h", c, p, r, w32, a, i);
   endtask

   task automatic push_bht(input logic [31:0] a, input logic t, input logic m);
      bq.push_back('{pc: a, taken: t, mis: m, cyc: cyc + 1});
   endtask

   task automatic push_fl(input logic [31:0] a, input logic m, input logic d, input logic f);
      fq.push_back('{pc: a, mret: m, dret: d, fencei: f, cyc: cyc + 1});
   endtask

   // Scoreboard side: pops expectations as the registered-flush instance produces them.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         if (bv1) begin
            if (bq.size() == 0) begin
               chk("bht_unexpected", 64'(bv1), 64'd0);
            end else begin
               be = bq.pop_front();
               chk("bht_cyc", 64'(cyc), 64'(be.cyc));
               chk("bht_pc", 64'(bpc1), 64'(be.pc));
               chk("bht_taken", 64'(bt1), 64'(be.taken));
               chk("bht_mis", 64'(bm1), 64'(be.mis));
            end
         end
         if (req1) begin
            if (fq.size() == 0) begin
               chk("flush_unexpected", 64'(req1), 64'd0);
            end else begin
               if (!fl_seen) begin
                  chk("flush_latency", 64'(cyc), 64'(fq[0].cyc));
                  fl_seen = 1'b1;
               end
               chk("flush_pc", 64'(fpc1), 64'(fq[0].pc));
               if (ack) begin
                  chk("flush_ena", 64'({mret1, dret1, fen1}),
                      64'({fq[0].mret, fq[0].dret, fq[0].fencei}));
                  fq.delete(0);
                  fl_seen = 1'b0;
               end
            end
         end else begin
            chk("ena_idle", 64'({mret1, dret1, fen1}), 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      clr_in();
      epc = 0; dpc = 0; exp_b = 0; exp_m = 0;
      rst_n = 0;
      repeat (3) @(posedge clk);
      neg();
      chk("rst_req", 64'(req1), 64'd0);
      chk("rst_pc", 64'(fpc1), 64'd0);
      chk("rst_bht", 64'(bv1), 64'd0);
      chk("rst_ena", 64'({mret1, dret1, fen1}), 64'd0);
      chk("rst_stat", 64'({sb1, sm1}), 64'd0);
      chk("rst_ready", 64'(r1), 64'd1);
      step();
      rst_n = 1; mon_en = 1;

      // Mispredicted bxx, ack held off for three pending cycles.
      step();
      br(1, 0, 1, 1, 32'h8000_0100, 32'h40);
      push_bht(32'h8000_0100, 1, 1); push_fl(32'h8000_0140, 0, 0, 0); exp_m = 1;
      neg(); chk("t1_ready_idle", 64'(r1), 64'd1);
      step();
      clr_in(); v1 = 1;
      for (int k = 0; k < 3; k++) begin
         neg();
         chk("t1_req_hold", 64'(req1), 64'd1);
         chk("t1_ready_pend", 64'(r1), 64'd0);
         step();
      end
      ack = 1;
      neg(); chk("t1_req_ack", 64'(req1), 64'd1); chk("t1_ready_ack", 64'(r1), 64'd0);
      step();
      clr_in(); v1 = 1;
      neg(); chk("t1_req_done", 64'(req1), 64'd0); chk("t1_ready_after", 64'(r1), 64'd1);

      // MRET, ack in the first pending cycle.
      step();
      clr_in(); epc = 32'h8000_0200; v1 = 1; mret = 1;
      $display("txn mret epc=%08h", epc);
      push_fl(32'h8000_0200, 1, 0, 0);
      neg(); chk("t2_ready", 64'(r1), 64'd1);
      step();
      clr_in(); ack = 1;
      neg(); chk("t2_mret_ena", 64'(mret1), 64'd1);
      step();
      clr_in();
      neg(); chk("t2_mret_off", 64'(mret1), 64'd0);
      chk("t2_stat_bxx", 64'(sb1), 64'(exp_b)); chk("t2_stat_mis", 64'(sm1), 64'(exp_m));

      // Compressed predicted-taken bxx that falls through past the top of the address space.
      step();
      br(1, 1, 0, 0, 32'hFFFF_FFFE, 32'h100);
      push_bht(32'hFFFF_FFFE, 0, 1); push_fl(32'h0, 0, 0, 0); exp_m = 2;
      step();
      clr_in(); ack = 1;
      neg(); chk("t3_wrap_pc", 64'(fpc1), 64'd0);
      step();
      clr_in();
      neg(); chk("t3_stat_mis", 64'(sm1), 64'(exp_m));

      // Exception flush blocks the branch in IDLE; accepted once it drops.
      step();
      br(1, 0, 1, 1, 32'h8000_0300, 32'hFFFF_FFF0);
      nonalu = 1;
      neg(); chk("t4_ready_blk", 64'(r1), 64'd0); chk("t4_req_blk", 64'(req1), 64'd0);
      step();
      neg(); chk("t4_req_idle", 64'(req1), 64'd0); chk("t4_ready_blk2", 64'(r1), 64'd0);
      nonalu = 0;
      push_bht(32'h8000_0300, 1, 1); push_fl(32'h8000_02F0, 0, 0, 0); exp_m = 3;
      #1; chk("t4_ready_rel", 64'(r1), 64'd1);
      step();
      clr_in(); ack = 1;
      step();
      clr_in();
      neg(); chk("t4_stat_mis", 64'(sm1), 64'(exp_m));

      // Back-to-back correct bxx saturate the 2-bit counter.
      for (int k = 0; k < 4; k++) begin
         step();
         br(1, k[0], k[0], 1, 32'h8000_0500 + 32'(8 * k), 32'h10);
         push_bht(32'h8000_0500 + 32'(8 * k), k[0], 0);
         if (exp_b < 3) exp_b++;
         neg(); chk("t5_ready", 64'(r1), 64'd1); chk("t5_noflush", 64'(req1), 64'd0);
      end
      step();
      clr_in();
      neg(); chk("t5_sat_bxx", 64'(sb1), 64'd3); chk("t5_sat_mis", 64'(sm1), 64'd3);
      step();
      br(1, 0, 0, 1, 32'h8000_0600, 32'h0);
      stat_clr = 1;
      push_bht(32'h8000_0600, 0, 0); exp_b = 0; exp_m = 0;
      step();
      clr_in();
      neg(); chk("t5_clr_bxx", 64'(sb1), 64'(exp_b)); chk("t5_clr_mis", 64'(sm1), 64'(exp_m));

      // Correctly predicted unconditional jump: no flush, no BHT update.
      step();
      br(0, 1, 1, 1, 32'h8000_0680, 32'h20);
      neg(); chk("jal_ready", 64'(r1), 64'd1);
      step();
      clr_in();
      neg(); chk("jal_noflush", 64'(req1), 64'd0);

      // FENCE.I with one cycle of ack delay, then DRET.
      step();
      clr_in(); v1 = 1; fencei = 1; pc = 32'h8000_0400;
      $display("txn fencei pc=%08h", pc);
      push_fl(32'h8000_0404, 0, 0, 1);
      step();
      clr_in();
      step();
      ack = 1;
      neg(); chk("fencei_ena", 64'(fen1), 64'd1);
      step();
      clr_in(); v1 = 1; dret = 1; dpc = 32'h8000_0700; epc = 32'h8000_0900;
      $display("txn dret dpc=%08h", dpc);
      push_fl(32'h8000_0700, 0, 1, 0);
      step();
      clr_in(); ack = 1;
      neg(); chk("dret_ena", 64'(dret1), 64'd1);
      step();
      clr_in();

      // Reset while pending drops the redirect without any side-effect pulse.
      step();
      br(0, 0, 1, 1, 32'h8000_0800, 32'h80);
      step();
      clr_in();
      #1; chk("t6_req_pend", 64'(req1), 64'd1);
      rst_n = 0; ack = 1;
      #1; chk("t6_req_async", 64'(req1), 64'd0);
      chk("t6_no_ena", 64'({mret1, dret1, fen1}), 64'd0);
      step();
      rst_n = 1;
      v1 = 1;
      neg(); chk("t6_idle_ready", 64'(r1), 64'd1); chk("t6_idle_req", 64'(req1), 64'd0);
      chk("t6_no_ena2", 64'({mret1, dret1, fen1}), 64'd0);
      chk("t6_stat", 64'({sb1, sm1}), 64'd0);

      // Pass-through instance against the combinational flush/ready equations.
      step();
      clr_in(); v0 = 1; bjp = 1; bxx = 1; prdt = 0; rslv = 1; pc = 32'h1000; imm = 32'h20;
      $display("txn comb branch pc=%08h imm=%08h", pc, imm);
      #1; chk("c_req", 64'(req0), 64'd1); chk("c_pc", 64'(fpc0), 64'h1020);
      chk("c_ready_noack", 64'(r0), 64'd0);
      ack = 1;
      #1; chk("c_ready_ack", 64'(r0), 64'd1); chk("c_req_ack", 64'(req0), 64'd1);
      nonalu = 1;
      #1; chk("c_req_nonalu", 64'(req0), 64'd0); chk("c_ready_nonalu", 64'(r0), 64'd0);
      clr_in(); v0 = 1; nonalu = 1;
      #1; chk("c_ready_nonbr", 64'(r0), 64'd1); chk("c_req_nonbr", 64'(req0), 64'd0);
      clr_in(); v0 = 1; mret = 1; epc = 32'h8000_0A00; ack = 1;
      #1; chk("c_mret_ena", 64'(mret0), 64'd1); chk("c_mret_pc", 64'(fpc0), 64'h8000_0A00);
      ack = 0;
      #1; chk("c_mret_noack", 64'(mret0), 64'd0); chk("c_mret_ready", 64'(r0), 64'd0);
      step();
      clr_in(); v0 = 1; bjp = 1; bxx = 1; prdt = 1; rslv = 1; pc = 32'h2000; imm = 32'h8;
      step();
      clr_in();
      neg(); chk("c_bht_valid", 64'(bv0), 64'd1); chk("c_bht_pc", 64'(bpc0), 64'h2000);
      chk("c_bht_tm", 64'({bt0, bm0}), 64'b10); chk("c_stat_off", 64'({sb0, sm0}), 64'd0);

      chk("bht_queue_empty", 64'(bq.size()), 64'd0);
      chk("flush_queue_empty", 64'(fq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/e203_exu_brslv_q.md
Name: e203_exu_brslv_q

Overview:
- Parametrised next-generation branch resolve unit at the EXU commit stage.
- Resolves mispredicted conditional branches/jumps, FENCE.I, MRET and DRET.
- Computes the full redirect PC and optionally registers the flush request, holding it until the IFU acknowledges.
- Also issues a BHT update per committed conditional branch and keeps saturating branch/mispredict statistics counters.

Parameters:
PC_W, 32, PC width in bits
XLEN, 32, immediate width; only imm[PC_W-1:0] is used
REG_FLUSH, 1, 1 = flush request/target registered and held until ack; 0 = combinational pass-through (legacy timing)
CNT_W, 32, statistics counter width
CNT_EN, 1, 0 = counters tied to 0 and not synthesised

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
cmt_i_valid  in  1  commit instruction valid
cmt_i_ready  out  1  commit instruction accepted
cmt_i_rv32  in  1  1 = 32-bit instruction, 0 = 16-bit
cmt_i_bjp  in  1  branch/jump
cmt_i_bxx  in  1  conditional branch (subset of bjp)
cmt_i_bjp_prdt  in  1  predicted taken
cmt_i_bjp_rslv  in  1  resolved taken
cmt_i_fencei  in  1  FENCE.I
cmt_i_mret  in  1  MRET
cmt_i_dret  in  1  DRET
cmt_i_pc  in  PC_W  instruction PC
cmt_i_imm  in  XLEN  branch offset
csr_epc_r  in  PC_W  MEPC
csr_dpc_r  in  PC_W  DPC
nonalu_excpirq_flush_req_raw  in  1  exception/IRQ flush; overrides branch flush
brchmis_flush_req  out  1  redirect request to IFU
brchmis_flush_ack  in  1  IFU accepts redirect
brchmis_flush_pc  out  PC_W  redirect target
cmt_mret_ena  out  1  one-cycle pulse on MRET flush handshake
cmt_dret_ena  out  1  one-cycle pulse on DRET flush handshake
cmt_fencei_ena  out  1  one-cycle pulse on FENCE.I flush handshake
bht_upd_valid  out  1  BHT update strobe
bht_upd_pc  out  PC_W  PC of the branch being updated
bht_upd_taken  out  1  resolved direction
bht_upd_mis  out  1  branch was mispredicted
stat_clr  in  1  synchronous clear of the counters
stat_bxx  out  CNT_W  correctly predicted conditional branches
stat_bxxmis  out  CNT_W  mispredicted conditional branches

Behaviour:
- is_br = bjp|fencei|mret|dret.
- need_flush = (bjp&(prdt^rslv))|fencei|mret|dret.
- Target PC, priority order:
  - dret: dpc
  - mret: epc
  - fencei or (bjp & prdt): pc + (rv32 ? 4 : 2)
  - otherwise: pc + imm[PC_W-1:0]
  - All additions modulo 2^PC_W; wrap-around is ignored.
- REG_FLUSH=0:
  - brchmis_flush_req = valid & need_flush & ~nonalu; flush_pc is combinational.
  - cmt_i_ready = ~is_br | ((need_flush ? ack : 1) & ~nonalu).
- REG_FLUSH=1, two-state FSM, reset state IDLE:
  - IDLE: cmt_i_ready = ~is_br | ~nonalu.
  - IDLE, valid & need_flush & ~nonalu: the instruction is accepted this cycle; target and kind (mret/dret/fencei) are captured; next state PEND.
  - IDLE, branch that needs no flush: accepted without a state change.
  - PEND: brchmis_flush_req=1 and flush_pc = captured target, both stable until ack; cmt_i_ready=0 for every instruction; nonalu raw is ignored.
  - PEND & ack: the matching *_ena pulses this cycle; next state IDLE. In the cycle after ack, ready already follows the IDLE rules.
  - Flush request latency is exactly 1 cycle after acceptance.
- Reset mid-PEND: the pending flush is dropped and no *_ena pulse is issued.
- BHT update:
  - Registered. On accept of valid & bxx, the next cycle has bht_upd_valid=1 with pc, taken=rslv, mis=prdt^rslv.
  - Single-cycle strobe; back-to-back accepts give back-to-back strobes.
- Counters:
  - Increment on accept of a bxx: stat_bxx when correctly predicted, stat_bxxmis when mispredicted.
  - Saturate at 2^CNT_W-1.
  - stat_clr takes priority over increment in the same cycle.
- Reset values: all outputs 0, FSM IDLE, captured target 0. cmt_i_ready is combinational.

Decomposition:
- Shared defines: FSM encoding (IDLE=1'b0, PEND=1'b1), PC-increment constants (4/2), counter-enable macro.
- Sub-module e203_exu_brslv_tgt: purely combinational target-PC mux/adder, reused by both REG_FLUSH modes.

Test Plan:
1. REG_FLUSH=1; bxx pc=0x80000100, imm=0x40, prdt=0, rslv=1; ack held off 3 cycles -> flush_req from cycle+1 for 4 cycles, flush_pc=0x80000140 throughout, ready=0 while pending, bht_upd mis=1 taken=1 at cycle+1.
2. MRET with epc=0x80000200, ack in the first PEND cycle -> flush_pc=0x80000200, cmt_mret_ena one-cycle pulse coincident with ack, stat counters unchanged.
3. Compressed bxx prdt=1, rslv=0, pc=0xFFFFFFFE -> flush_pc=0x00000000 (wrap), stat_bxxmis+1.
4. Branch needing flush with nonalu raw=1 in IDLE -> ready=0, no flush, FSM stays IDLE; raw drops -> accepted next cycle.
5. Counters with CNT_W=2: 4 correct bxx -> stat_bxx=3 (saturates); stat_clr asserted with a bxx accept in the same cycle -> stat_bxx=0.
6. rst_n asserted during PEND -> flush_req=0 immediately (asynchronous), no *_ena pulse, IDLE after release; REG_FLUSH=0 regression matches the combinational equations above.
